// File: rtl/iq_decim_tap_line.sv
// Multi-channel decimating tap-delay line: keeps 1 of every DECIM valid samples, exposes last DEPTH per channel.
// Latency: taps_out/shift_pulse update one cycle after an accepted input sample.
// No backpressure: every in_valid is consumed; optional phase_sel port under `TDL_PHASE_SEL_EN.
module iq_decim_tap_line #(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 20,
  parameter int DECIM  = 5,
  parameter int NCH    = 2,
  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1,
  localparam int FC_W  = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          in_valid,
  input  logic [NCH*DATA_W-1:0]         in_data,
`ifdef TDL_PHASE_SEL_EN
  input  logic [PH_W-1:0]               phase_sel,
`endif
  output logic [NCH*DEPTH*DATA_W-1:0]   taps_out,
  output logic                          shift_pulse,
  output logic [FC_W-1:0]               fill_count,
  output logic                          full,
  output logic [PH_W-1:0]               phase
);

  localparam logic [PH_W-1:0] LAST_PH = PH_W'(DECIM - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(DEPTH - 1);

  logic [DATA_W-1:0] tap_q [NCH][DEPTH];
  logic [PH_W-1:0]   keep_phase;
  logic              accept;

`ifdef TDL_PHASE_SEL_EN
  // Selected keep phase, clamped into the legal 0..DECIM-1 range
  always_comb begin
    keep_phase = phase_sel;
    if (phase_sel > LAST_PH) keep_phase = LAST_PH;
  end
`else
  assign keep_phase = LAST_PH;
`endif

  // clear wins over a same-cycle valid, so the sample is dropped
  assign accept = in_valid && !clear && (phase == keep_phase);

  // Decimation phase: advances on every valid, wraps after DECIM-1
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      phase <= '0;
    end else if (in_valid) begin
      if (phase >= LAST_PH) phase <= '0;
      else                  phase <= phase + 1'b1;
    end
  end

  // Tap shift: all channels move in lockstep on an accept, oldest falls off
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < DEPTH; k++) begin
          tap_q[c][k] <= '0;
        end
      end
    end else if (accept) begin
      for (int c = 0; c < NCH; c++) begin
        tap_q[c][0] <= in_data[c*DATA_W +: DATA_W];
        for (int k = 1; k < DEPTH; k++) begin
          tap_q[c][k] <= tap_q[c][k-1];
        end
      end
    end
  end

  // Fill tracking and shift strobe; full is kept in step with fill_count
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      fill_count  <= '0;
      full        <= 1'b0;
      shift_pulse <= 1'b0;
    end else begin
      shift_pulse <= accept;
      if (accept && !full) begin
        fill_count <= fill_count + 1'b1;
        full       <= (fill_count == FC_LAST);
      end
    end
  end

  // Flatten the tap array onto the parallel output bus
  always_comb begin
    taps_out = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < DEPTH; k++) begin
        taps_out[(c*DEPTH+k)*DATA_W +: DATA_W] = tap_q[c][k];
      end
    end
  end

endmodule
